vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_VISIBLE, 640: active pixels per line
- H_FRONT, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BACK, 48: horizontal back porch, pixels
- V_VISIBLE, 480: active lines
- V_FRONT, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BACK, 33: vertical back porch, lines
- PF_X0, 0: playfield left column
- PF_Y0, 0: playfield top line
- PF_W, 640: playfield width
- PF_H, 480: playfield height

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock_25, in, 1: pixel clock
- reset, in, 1: reset
- hsync, out, 1: horizontal sync, active-low
- vsync, out, 1: vertical sync, active-low
- display_area, out, 1: current pixel is visible
- game_window, out, 1: current pixel is inside the playfield
- pixel_x, out, 10: current column
- pixel_y, out, 10: current line
- frame_start, out, 1: one-cycle pulse at the first pixel of a frame
- line_end, out, 1: one-cycle pulse at the last pixel of each line

REQ-003 There SHALL be one clock, clock_25; reset SHALL be asynchronous and active-high.

Function
REQ-004 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).

REQ-005 The internal h_count SHALL advance by 1 on every clock_25 edge and wrap from H_TOTAL-1 to 0.

REQ-006 The internal v_count SHALL advance by 1 only on the edge where h_count wraps; it SHALL wrap from V_TOTAL-1 to 0 on the same edge that h_count wraps.

REQ-007 pixel_x SHALL equal h_count and pixel_y SHALL equal v_count in every cycle, including blanking; there SHALL be no saturation.

REQ-008 All outputs SHALL be registered, with no combinational path from counter to port.
- Each output SHALL describe the same (pixel_x, pixel_y) presented in that cycle, with zero relative skew.
- This is implemented by decoding the next counter value.

REQ-009 display_area SHALL be 1 iff pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.

REQ-010 hsync SHALL be 0 iff H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).

REQ-011 vsync SHALL be 0 iff V_VISIBLE+V_FRONT <= pixel_y < V_VISIBLE+V_FRONT+V_SYNC (default lines 490..491), for entire lines.

REQ-012 game_window SHALL be 1 iff display_area=1 and PF_X0 <= pixel_x < PF_X0+PF_W and PF_Y0 <= pixel_y < PF_Y0+PF_H.
- game_window SHALL never be 1 outside the visible area, even if the playfield parameters exceed it.

REQ-013 frame_start SHALL be 1 only in the cycle where (pixel_x, pixel_y) = (0, 0).

REQ-014 line_end SHALL be 1 only in cycles where pixel_x = H_TOTAL-1, on every line including vertical blanking.

REQ-015 Counter comparisons SHALL use at least 10-bit unsigned arithmetic; with the default parameters no intermediate value SHALL overflow.

Reset
REQ-016 While reset=1, the block SHALL hold the last pixel of the frame:
- h_count = H_TOTAL-1 and v_count = V_TOTAL-1
- pixel_x = 799, pixel_y = 524
- hsync = 1, vsync = 1
- display_area = 0, game_window = 0, frame_start = 0
- line_end = 0: forced low during reset, overriding REQ-014.

REQ-017 On the first clock_25 edge after reset deasserts, the outputs SHALL show (0,0) with display_area=1 and frame_start=1.

REQ-018 Asserting reset mid-frame SHALL force the REQ-016 values immediately, without waiting for a clock edge; no partial-frame state SHALL survive.

Verification
REQ-019 Reset then release -> pixel_x=799, pixel_y=524, hsync=vsync=1 during reset; first edge after release gives pixel_x=0, pixel_y=0, display_area=1, frame_start=1.

REQ-020 Run one line -> hsync low for exactly 96 consecutive cycles starting at pixel_x=656; line_end high only at pixel_x=799; pixel_y increments at the 800-cycle wrap.

REQ-021 Run 2 full frames -> frame_start period exactly 420000 cycles; vsync low for exactly 1600 cycles starting at pixel_y=490, pixel_x=0; display_area high for exactly 307200 cycles per frame.

REQ-022 Wrap check -> (799,524) is followed by (0,0); (799,479) is followed by (0,480) with display_area=0.

REQ-023 Set PF_X0=160, PF_Y0=120, PF_W=320, PF_H=240 -> game_window high for exactly 76800 cycles per frame; first high at (160,120), last high at (479,359).

REQ-024 Assert reset asynchronously at (300,200) for 3 cycles -> outputs take the REQ-016 values before the next edge; after release, outputs restart at (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Pixel/line counter and sync generator for a VGA raster (640x480@60 by
//   default), with a rectangular playfield window decode.
//
// Ports
//   clock_25      in   pixel clock
//   reset         in   asynchronous, active-high; holds the last pixel of frame
//   hsync         out  horizontal sync, active-low
//   vsync         out  vertical sync, active-low (whole lines)
//   display_area  out  current pixel lies in the visible region
//   game_window   out  current pixel lies in the playfield (and is visible)
//   pixel_x       out  current column (h_count), including blanking
//   pixel_y       out  current line (v_count), including blanking
//   frame_start   out  one-cycle pulse at pixel (0,0)
//   line_end      out  one-cycle pulse at pixel_x = H_TOTAL-1, every line
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned PF_X0     = 0,
  parameter int unsigned PF_Y0     = 0,
  parameter int unsigned PF_W      = 640,
  parameter int unsigned PF_H      = 480
) (
  input  logic       clock_25,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_area,
  output logic       game_window,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  output logic       line_end
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Comparisons are done at 16 bits so that porch/playfield sums never wrap.
  localparam int unsigned CW = 16;

  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] PF_XL    = CW'(PF_X0);
  localparam logic [CW-1:0] PF_XR    = CW'(PF_X0 + PF_W);
  localparam logic [CW-1:0] PF_YT    = CW'(PF_Y0);
  localparam logic [CW-1:0] PF_YB    = CW'(PF_Y0 + PF_H);

  logic [9:0] h_count, v_count;
  logic [9:0] h_next,  v_next;
  logic       h_wrap,  v_wrap;

  logic [CW-1:0] hx, vy;
  logic          hsync_nx, vsync_nx, disp_nx, gw_nx, fs_nx, le_nx;
  logic          in_pf_x, in_pf_y;

  // ---------------------------------------------------------------------------
  // Next counter values
  // ---------------------------------------------------------------------------
  always_comb begin
    h_wrap = (h_count == H_LAST);
    v_wrap = (v_count == V_LAST);
    h_next = h_wrap ? '0 : h_count + 10'd1;
    if (h_wrap)
      v_next = v_wrap ? '0 : v_count + 10'd1;
    else
      v_next = v_count;
  end

  // ---------------------------------------------------------------------------
  // Decode of the *next* pixel position, so that each registered flag lines
  // up with the pixel_x/pixel_y presented in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    hx       = {{(CW-10){1'b0}}, h_next};
    vy       = {{(CW-10){1'b0}}, v_next};
    disp_nx  = (hx < H_VIS) && (vy < V_VIS);
    hsync_nx = !((hx >= HS_START) && (hx < HS_END));
    vsync_nx = !((vy >= VS_START) && (vy < VS_END));
    in_pf_x  = (hx >= PF_XL) && (hx < PF_XR);
    in_pf_y  = (vy >= PF_YT) && (vy < PF_YB);
    // Gated by the visible decode so an oversized playfield cannot leak
    // into blanking.
    gw_nx    = disp_nx && in_pf_x && in_pf_y;
    fs_nx    = (h_next == '0) && (v_next == '0);
    le_nx    = (h_next == H_LAST);
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Reset parks the raster on the final pixel so
  // that the first edge after release lands exactly on (0,0).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      h_count      <= H_LAST;
      v_count      <= V_LAST;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      display_area <= 1'b0;
      game_window  <= 1'b0;
      frame_start  <= 1'b0;
      line_end     <= 1'b0;
    end else begin
      h_count      <= h_next;
      v_count      <= v_next;
      hsync        <= hsync_nx;
      vsync        <= vsync_nx;
      display_area <= disp_nx;
      game_window  <= gw_nx;
      frame_start  <= fs_nx;
      line_end     <= le_nx;
    end
  end

  assign pixel_x = h_count;
  assign pixel_y = v_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = -1;   // pixel clocks since reset release; -1 while held in reset

  // Instance D: default 640x480 timing.
  logic       hs_d, vs_d, da_d, gw_d, fs_d, le_d;
  logic [9:0] x_d, y_d;
  // Instance A: reduced raster (25x15 total, 16x8 visible), playfield inside.
  logic       hs_a, vs_a, da_a, gw_a, fs_a, le_a;
  logic [9:0] x_a, y_a;
  // Instance B: reduced raster, playfield overhanging the visible area.
  logic       hs_b, vs_b, da_b, gw_b, fs_b, le_b;
  logic [9:0] x_b, y_b;

  vga_timing_gen dut_d (
    .clock_25(clk), .reset(rst), .hsync(hs_d), .vsync(vs_d),
    .display_area(da_d), .game_window(gw_d), .pixel_x(x_d), .pixel_y(y_d),
    .frame_start(fs_d), .line_end(le_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .PF_X0(4), .PF_Y0(2), .PF_W(8), .PF_H(4)
  ) dut_a (
    .clock_25(clk), .reset(rst), .hsync(hs_a), .vsync(vs_a),
    .display_area(da_a), .game_window(gw_a), .pixel_x(x_a), .pixel_y(y_a),
    .frame_start(fs_a), .line_end(le_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .PF_X0(10), .PF_Y0(5), .PF_W(20), .PF_H(10)
  ) dut_b (
    .clock_25(clk), .reset(rst), .hsync(hs_b), .vsync(vs_b),
    .display_area(da_b), .game_window(gw_b), .pixel_x(x_b), .pixel_y(y_b),
    .frame_start(fs_b), .line_end(le_b)
  );

  logic [77:0] obs_all;
  assign obs_all = {hs_d, vs_d, da_d, gw_d, fs_d, le_d, x_d, y_d,
                    hs_a, vs_a, da_a, gw_a, fs_a, le_a, x_a, y_a,
                    hs_b, vs_b, da_b, gw_b, fs_b, le_b, x_b, y_b};

  // Raster model: position follows from elapsed pixel clocks by division.
  function automatic logic [25:0] model(int hv, int hf, int hs, int hb,
                                        int vv, int vf, int vs, int vb,
                                        int px, int py, int pw, int ph, int tt);
    int ht, vt, x, y;
    logic d, g, h, v, f, l;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (tt < 0) return {1'b1, 1'b1, 4'b0000, 10'(ht - 1), 10'(vt - 1)};
    x = tt % ht;
    y = (tt / ht) % vt;
    d = (x < hv) && (y < vv);
    h = !((x >= hv + hf) && (x < hv + hf + hs));
    v = !((y >= vv + vf) && (y < vv + vf + vs));
    g = d && (x >= px) && (x < px + pw) && (y >= py) && (y < py + ph);
    f = (x == 0) && (y == 0);
    l = (x == ht - 1);
    return {h, v, d, g, f, l, 10'(x), 10'(y)};
  endfunction

  function automatic logic [77:0] exp_all(int tt);
    return {model(640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 640, 480, tt),
            model(16, 2, 3, 4, 8, 2, 2, 3, 4, 2, 8, 4, tt),
            model(16, 2, 3, 4, 8, 2, 2, 3, 10, 5, 20, 10, tt)};
  endfunction

  // Advance one pixel clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) t = t + 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    t = -1;
    repeat (4) begin
      tick();
      checks++;
      if (obs_all !== exp_all(t)) begin
        errors++;
        $display("FAIL reset_hold t=%0d got %h want %h", t, obs_all, exp_all(t));
      end
    end
    checks++;
    if ({x_d, y_d, hs_d, vs_d, le_d} !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got x=%0d y=%0d hs=%b vs=%b le=%b want 799 524 1 1 0",
               x_d, y_d, hs_d, vs_d, le_d);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if ({x_d, y_d, da_d, fs_d} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL first_edge got x=%0d y=%0d da=%b fs=%b want 0 0 1 1",
               x_d, y_d, da_d, fs_d);
    end
    checks++;
    if (obs_all !== exp_all(t)) begin
      errors++;
      $display("FAIL first_edge_all got %h want %h", obs_all, exp_all(t));
    end
  endtask

  // One full default-timing line plus the wrap into line 1.
  task automatic test_line();
    int low_cnt = 0, low_first = -1, falls = 0, le_cnt = 0, le_x = -1;
    logic prev_hs = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (!hs_d) begin
        low_cnt++;
        if (low_first < 0) low_first = int'(x_d);
      end
      if (prev_hs && !hs_d) falls++;
      prev_hs = hs_d;
      if (le_d) begin
        le_cnt++;
        le_x = int'(x_d);
      end
      tick();
      checks++;
      if (obs_all !== exp_all(t)) begin
        errors++;
        $display("FAIL line_cycle t=%0d got %h want %h", t, obs_all, exp_all(t));
      end
    end
    checks++;
    if (low_cnt != 96 || low_first != 656 || falls != 1) begin
      errors++;
      $display("FAIL hsync_pulse got len=%0d start=%0d falls=%0d want 96 656 1",
               low_cnt, low_first, falls);
    end
    checks++;
    if (le_cnt != 1 || le_x != 799) begin
      errors++;
      $display("FAIL line_end got count=%0d x=%0d want 1 799", le_cnt, le_x);
    end
    checks++;
    if (x_d !== 10'd0 || y_d !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap got x=%0d y=%0d want 0 1", x_d, y_d);
    end
  endtask

  // Two full frames of the reduced raster.
  task automatic test_frames();
    int fs_t[$];
    int vs_cnt = 0, vs_fx = -1, vs_fy = -1;
    int da_cnt0 = 0, da_cnt1 = 0, gwa_cnt = 0, gwb_cnt = 0;
    int gw_fx = -1, gw_fy = -1, gw_lx = -1, gw_ly = -1;
    rst = 1'b1;
    t = -1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 751; c++) begin
      tick();
      checks++;
      if (obs_all !== exp_all(t)) begin
        errors++;
        $display("FAIL frame_cycle t=%0d got %h want %h", t, obs_all, exp_all(t));
      end
      if (fs_a) fs_t.push_back(t);
      if (t < 375) begin
        if (!vs_a) begin
          vs_cnt++;
          if (vs_fx < 0) begin vs_fx = int'(x_a); vs_fy = int'(y_a); end
        end
        if (da_a) da_cnt0++;
        if (gw_b) gwb_cnt++;
        if (gw_a) begin
          gwa_cnt++;
          if (gw_fx < 0) begin gw_fx = int'(x_a); gw_fy = int'(y_a); end
          gw_lx = int'(x_a);
          gw_ly = int'(y_a);
        end
      end else if (t < 750) begin
        if (da_a) da_cnt1++;
      end
    end
    checks++;
    if (fs_t.size() != 3) begin
      errors++;
      $display("FAIL frame_start_count got %0d want 3", fs_t.size());
    end else begin
      checks++;
      if (fs_t[1] - fs_t[0] != 375 || fs_t[2] - fs_t[1] != 375) begin
        errors++;
        $display("FAIL frame_period got %0d,%0d want 375",
                 fs_t[1] - fs_t[0], fs_t[2] - fs_t[1]);
      end
    end
    checks++;
    if (vs_cnt != 50 || vs_fx != 0 || vs_fy != 10) begin
      errors++;
      $display("FAIL vsync_pulse got len=%0d at (%0d,%0d) want 50 at (0,10)",
               vs_cnt, vs_fx, vs_fy);
    end
    checks++;
    if (da_cnt0 != 128 || da_cnt1 != 128) begin
      errors++;
      $display("FAIL display_count got %0d,%0d want 128", da_cnt0, da_cnt1);
    end
    checks++;
    if (gwa_cnt != 32 || gw_fx != 4 || gw_fy != 2 || gw_lx != 11 || gw_ly != 5) begin
      errors++;
      $display("FAIL game_window got n=%0d first=(%0d,%0d) last=(%0d,%0d) want 32 (4,2) (11,5)",
               gwa_cnt, gw_fx, gw_fy, gw_lx, gw_ly);
    end
    checks++;
    if (gwb_cnt != 18) begin
      errors++;
      $display("FAIL game_window_clamp got %0d want 18", gwb_cnt);
    end
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (!(x_a == 10'd24 && y_a == 10'd7) && guard < 400) begin
      tick();
      guard++;
    end
    tick();
    checks++;
    if ({x_a, y_a, da_a} !== {10'd0, 10'd8, 1'b0} || guard >= 400) begin
      errors++;
      $display("FAIL wrap_visible got x=%0d y=%0d da=%b guard=%0d want 0 8 0",
               x_a, y_a, da_a, guard);
    end
    guard = 0;
    while (!(x_a == 10'd24 && y_a == 10'd14) && guard < 400) begin
      tick();
      guard++;
    end
    tick();
    checks++;
    if ({x_a, y_a, fs_a} !== {10'd0, 10'd0, 1'b1} || guard >= 400) begin
      errors++;
      $display("FAIL wrap_frame got x=%0d y=%0d fs=%b guard=%0d want 0 0 1",
               x_a, y_a, fs_a, guard);
    end
  endtask

  // Reset mid-frame between edges; values must change before the next edge.
  task automatic async_reset(int pre, int hold, int post, string tag);
    #(pre);
    rst = 1'b1;
    t = -1;
    #1;
    checks++;
    if (obs_all !== exp_all(-1)) begin
      errors++;
      $display("FAIL %s_immediate got %h want %h", tag, obs_all, exp_all(-1));
    end
    repeat (hold) begin
      tick();
      checks++;
      if (obs_all !== exp_all(t)) begin
        errors++;
        $display("FAIL %s_hold got %h want %h", tag, obs_all, exp_all(t));
      end
    end
    #(post);
    rst = 1'b0;
    tick();
    checks++;
    if (obs_all !== exp_all(t) || fs_a !== 1'b1 || fs_d !== 1'b1) begin
      errors++;
      $display("FAIL %s_restart got %h want %h", tag, obs_all, exp_all(t));
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!(x_a == 10'd12 && y_a == 10'd4) && guard < 400) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL async_reach got guard=%0d want <400", guard);
    end
    async_reset(5, 3, 10, "async");
  endtask

  task automatic test_random_resets();
    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(50, 900));
      for (int c = 0; c < n; c++) begin
        tick();
        checks++;
        if (obs_all !== exp_all(t)) begin
          errors++;
          $display("FAIL rand_run t=%0d got %h want %h", t, obs_all, exp_all(t));
        end
      end
      async_reset(int'($urandom_range(2, 30)), int'($urandom_range(1, 4)),
                  int'($urandom_range(1, 30)), "rand_reset");
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired at t=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_wrap();
    test_async_reset();
    test_random_resets();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
